// File: rtl/vga_timing_gen_if.sv
// Pixel-side and pin-side signals of the VGA raster timing generator.
// master = timing generator, slave = pixel source / pin driver / bench.
interface vga_timing_gen_if #(
    parameter int PIX_W = 16,
    parameter int CNT_W = 12
);
    logic             timing_en;
    logic [1:0]       scale_sel;
    logic [PIX_W-1:0] pix_data;
    logic             pix_req;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    logic             hsync;
    logic             vsync;
    logic             rgb_valid;
    logic [PIX_W-1:0] rgb;
    logic             line_start;
    logic             frame_start;
    logic [7:0]       frame_cnt;

    modport master (
        input  timing_en, scale_sel, pix_data,
        output pix_req, pix_x, pix_y, hsync, vsync, rgb_valid, rgb,
               line_start, frame_start, frame_cnt
    );

    modport slave (
        output timing_en, scale_sel, pix_data,
        input  pix_req, pix_x, pix_y, hsync, vsync, rgb_valid, rgb,
               line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-request lead,
// runtime 1x/2x/4x scaling, timing enable, strobes and frame counter.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int PIX_W     = 16,
    parameter int CNT_W     = 12,
    parameter int REQ_LEAD  = 1
) (
    input  logic             vga_clk,
    input  logic             sys_rst,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_DISP_W = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_DISP_W = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [CNT_W:0]   H_TOT_W  = (CNT_W+1)'(H_TOTAL);
    localparam logic [CNT_W:0]   LEAD_W   = (CNT_W+1)'(REQ_LEAD);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hcnt, vcnt;
    logic [1:0]       scale_q;
    logic             first_q;
    logic             active, at_origin;

    logic [CNT_W:0]   h_sum;
    logic             lead_wrap, frame_wrap;
    logic [CNT_W-1:0] h_req, v_req;
    logic [1:0]       req_sel, req_sh;
    logic             req_vis;

    logic             pix_req_q, hsync_q, vsync_q, rgb_valid_q, line_start_q, frame_start_q;
    logic [CNT_W-1:0] pix_x_q, pix_y_q;
    logic [7:0]       frame_cnt_q;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vga.timing_en)  state_d = RUN;
            RUN:     if (!vga.timing_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign active    = (state_q == RUN) && vga.timing_en;
    assign at_origin = (state_q == RUN) && (hcnt == '0) && (vcnt == '0);

    // The IDLE cycle after an enable rise holds (0,0) so the raster starts cleanly there.
    always_ff @(posedge vga_clk) begin
        if (sys_rst || !vga.timing_en || state_q != RUN) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Request position is the counter advanced by REQ_LEAD; requests that wrap into
    // the next frame (or sit at the origin) use the scale about to be latched.
    always_comb begin
        h_sum      = {1'b0, hcnt} + LEAD_W;
        lead_wrap  = (h_sum >= H_TOT_W);
        h_req      = lead_wrap ? CNT_W'(h_sum - H_TOT_W) : h_sum[CNT_W-1:0];
        frame_wrap = lead_wrap && (vcnt == V_LAST);
        if (!lead_wrap)      v_req = vcnt;
        else if (frame_wrap) v_req = '0;
        else                 v_req = vcnt + 1'b1;
        req_sel = (at_origin || frame_wrap) ? vga.scale_sel : scale_q;
        case (req_sel)
            2'd1:    req_sh = 2'd1;
            2'd2:    req_sh = 2'd2;
            default: req_sh = 2'd0;
        endcase
        req_vis = (h_req < H_DISP_W) && (v_req < V_DISP_W);
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            pix_req_q     <= 1'b0;
            pix_x_q       <= '1;
            pix_y_q       <= '1;
            hsync_q       <= !HS_POL;
            vsync_q       <= !VS_POL;
            rgb_valid_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            scale_q       <= '0;
            frame_cnt_q   <= '0;
            first_q       <= 1'b1;
        end else if (!active) begin
            pix_req_q     <= 1'b0;
            pix_x_q       <= '1;
            pix_y_q       <= '1;
            hsync_q       <= !HS_POL;
            vsync_q       <= !VS_POL;
            rgb_valid_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            first_q       <= 1'b1;
        end else begin
            pix_req_q     <= req_vis;
            pix_x_q       <= req_vis ? (h_req >> req_sh) : '1;
            pix_y_q       <= req_vis ? (v_req >> req_sh) : '1;
            hsync_q       <= (hcnt >= HS_FIRST && hcnt <= HS_LAST) ? HS_POL : !HS_POL;
            vsync_q       <= (vcnt >= VS_FIRST && vcnt <= VS_LAST) ? VS_POL : !VS_POL;
            rgb_valid_q   <= (hcnt < H_DISP_W) && (vcnt < V_DISP_W);
            line_start_q  <= (hcnt == '0);
            frame_start_q <= at_origin;
            if (at_origin) begin
                scale_q <= vga.scale_sel;
                first_q <= 1'b0;
                if (!first_q) frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign vga.pix_req     = pix_req_q;
    assign vga.pix_x       = pix_x_q;
    assign vga.pix_y       = pix_y_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.rgb_valid   = rgb_valid_q;
    assign vga.rgb         = rgb_valid_q ? vga.pix_data : '0;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster (24x13, lead 3, active-high hsync).
module tb_vga_timing_gen;
    localparam int HD = 16, HF = 2, HS = 3, HB = 3;
    localparam int VD = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int L  = 3;
    localparam bit HP = 1'b1, VP = 1'b0;
    localparam int N_CYC = 2600;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.PIX_W(16), .CNT_W(12)) vif ();

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HS_POL(HP), .VS_POL(VP), .PIX_W(16), .CNT_W(12), .REQ_LEAD(L)
    ) dut (
        .vga_clk(clk),
        .sys_rst(rst),
        .vga    (vif)
    );

    typedef struct {
        logic        req;
        logic [11:0] x, y;
        logic        hs, vs, val;
        logic [15:0] rgb;
        logic        ls, fs;
        logic [7:0]  fc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    exp_t me;
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            me = sb.pop_front();
            chk("pix_req",     {31'd0, vif.pix_req},     {31'd0, me.req});
            chk("pix_x",       {20'd0, vif.pix_x},       {20'd0, me.x});
            chk("pix_y",       {20'd0, vif.pix_y},       {20'd0, me.y});
            chk("hsync",       {31'd0, vif.hsync},       {31'd0, me.hs});
            chk("vsync",       {31'd0, vif.vsync},       {31'd0, me.vs});
            chk("rgb_valid",   {31'd0, vif.rgb_valid},   {31'd0, me.val});
            chk("rgb",         {16'd0, vif.rgb},         {16'd0, me.rgb});
            chk("line_start",  {31'd0, vif.line_start},  {31'd0, me.ls});
            chk("frame_start", {31'd0, vif.frame_start}, {31'd0, me.fs});
            chk("frame_cnt",   {24'd0, vif.frame_cnt},   {24'd0, me.fc});
        end
    end

    // Raster model state: pos is the linear raster position of the counter.
    exp_t       e;
    logic       run_m, first_m;
    logic [7:0] fc_m;
    logic [1:0] sc_m, s;
    int         pos, h, v, rp, hr, vr, sh;

    initial begin
        rst = 1'b1;
        vif.timing_en = 1'b1;
        vif.scale_sel = 2'd0;
        vif.pix_data  = 16'h0;
        run_m = 1'b0; first_m = 1'b1; fc_m = 8'd0; sc_m = 2'd0; pos = 0;

        for (int n = 0; n < N_CYC; n++) begin
            @(posedge clk);
            e.req = 1'b0; e.x = 12'hFFF; e.y = 12'hFFF;
            e.hs = !HP; e.vs = !VP; e.val = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
            if (rst) begin
                run_m = 1'b0; pos = 0; first_m = 1'b1; fc_m = 8'd0; sc_m = 2'd0;
            end else if (!vif.timing_en) begin
                run_m = 1'b0; pos = 0; first_m = 1'b1;
            end else if (!run_m) begin
                run_m = 1'b1; pos = 0;
            end else begin
                h = pos % HT;
                v = pos / HT;
                if (pos == 0) begin
                    sc_m = vif.scale_sel;
                    if (!first_m) fc_m = fc_m + 8'd1;
                    first_m = 1'b0;
                end
                rp = pos + L;
                s  = (rp >= FT) ? vif.scale_sel : sc_m;
                rp = rp % FT;
                hr = rp % HT;
                vr = rp / HT;
                sh = (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : 0;
                if (hr < HD && vr < VD) begin
                    e.req = 1'b1;
                    e.x   = 12'(hr >> sh);
                    e.y   = 12'(vr >> sh);
                end
                e.hs  = (h >= HD + HF && h < HD + HF + HS) ? HP : !HP;
                e.vs  = (v >= VD + VF && v < VD + VF + VS) ? VP : !VP;
                e.val = (h < HD) && (v < VD);
                e.ls  = (h == 0);
                e.fs  = (pos == 0);
                pos   = (pos + 1) % FT;
            end
            e.fc = fc_m;

            #1;
            // Inputs for the next edge: reset, mid-frame scale changes, a disable window, a 1-cycle reset.
            rst = (n < 2) || (n == 2000);
            vif.timing_en = !(n >= 1499 && n < 1509);
            vif.scale_sel = (n < 100) ? 2'd0 : (n < 400) ? 2'd1 : (n < 700) ? 2'd2 : 2'd3;
            vif.pix_data  = e.val ? 16'($urandom) : 16'hFFFF;
            e.rgb = e.val ? vif.pix_data : 16'h0;
            sb.push_back(e);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
